// File: rtl/csr_exec_unit.sv
// csr_exec_unit: executes Zicsr instructions (CSRRW/RS/RC and immediate
// forms) against a machine-mode CSR file. One instruction in flight: it
// reads the CSR, issues at most one write, then returns the old value and
// an illegal-instruction flag through a valid/ready response port.
module csr_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            ctrl_clk,
  input  logic            ctrl_reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_csr,
  input  logic [4:0]      req_src,
  input  logic [XLEN-1:0] req_rs1_val,
  input  logic [1:0]      req_priv,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            csr_wen,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  // Latched instruction fields
  logic [2:0]      funct3_q;
  logic [11:0]     csr_q;
  logic [4:0]      src_q;
  logic [XLEN-1:0] rs1_q;
  logic [1:0]      priv_q;

  // Results computed in READ, presented in WRITE/RESP
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] wdata_q;
  logic            illegal_q;
  logic            wen_q;

  // Decode of the latched instruction against the live read data
  logic [XLEN-1:0] op;
  logic [XLEN-1:0] new_val;
  logic            do_write;
  logic            illegal;

  // Operand select, read-modify-write value and legality checks.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (avoids a latch).
    op       = funct3_q[2] ? {{(XLEN-5){1'b0}}, src_q} : rs1_q;
    new_val  = op;
    do_write = 1'b0;
    case (funct3_q[1:0])
      2'b01: begin
        new_val  = op;
        do_write = 1'b1;
      end
      2'b10: begin
        new_val  = csr_rdata | op;
        do_write = (src_q != 5'd0);
      end
      2'b11: begin
        new_val  = csr_rdata & ~op;
        do_write = (src_q != 5'd0);
      end
      default: begin
        new_val  = op;
        do_write = 1'b0;
      end
    endcase
    // Reserved funct3, insufficient privilege, or a write to a read-only CSR.
    illegal = (funct3_q[1:0] == 2'b00)
           || (priv_q < csr_q[9:8])
           || (do_write && (csr_q[11:10] == 2'b11));
  end

  // State register.
  always_ff @(posedge ctrl_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (ctrl_reset) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Capture the request in IDLE and the CSR read result in READ.
  always_ff @(posedge ctrl_clk) begin
    // NOTE: datapath registers are reset too; outputs are gated by state, but zeros keep X out of simulation.
    if (ctrl_reset) begin
      funct3_q  <= '0;
      csr_q     <= '0;
      src_q     <= '0;
      rs1_q     <= '0;
      priv_q    <= '0;
      rdata_q   <= '0;
      wdata_q   <= '0;
      illegal_q <= 1'b0;
      wen_q     <= 1'b0;
    end else begin
      if (state_q == S_IDLE && req_valid) begin
        funct3_q <= req_funct3;
        csr_q    <= req_csr;
        src_q    <= req_src;
        rs1_q    <= req_rs1_val;
        priv_q   <= req_priv;
      end
      if (state_q == S_READ) begin
        rdata_q   <= illegal ? '0 : csr_rdata;
        wdata_q   <= new_val;
        illegal_q <= illegal;
        wen_q     <= do_write && !illegal;
      end
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    csr_addr     = '0;
    csr_wen      = 1'b0;
    csr_wdata    = '0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_illegal = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_READ;
      end
      S_READ: begin
        csr_addr = csr_q;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        csr_addr  = csr_q;
        csr_wen   = wen_q;
        csr_wdata = wen_q ? wdata_q : '0;
        state_d   = S_RESP;
      end
      S_RESP: begin
        resp_valid   = 1'b1;
        resp_rdata   = rdata_q;
        resp_illegal = illegal_q;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_exec_unit.sv
// Scoreboard bench for csr_exec_unit: the driver pushes expected writes and
// responses, a negedge monitor pops and compares them as the DUT emits them.
module tb_csr_exec_unit;

  localparam int XLEN = 32;

  logic            ctrl_clk;
  logic            ctrl_reset;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [11:0]     req_csr;
  logic [4:0]      req_src;
  logic [XLEN-1:0] req_rs1_val;
  logic [1:0]      req_priv;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_wen;
  logic [XLEN-1:0] csr_rdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_illegal;

  csr_exec_unit #(.XLEN(XLEN)) dut (
    .ctrl_clk     (ctrl_clk),
    .ctrl_reset   (ctrl_reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_csr      (req_csr),
    .req_src      (req_src),
    .req_rs1_val  (req_rs1_val),
    .req_priv     (req_priv),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .csr_wen      (csr_wen),
    .csr_rdata    (csr_rdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_illegal (resp_illegal)
  );

  initial ctrl_clk = 1'b0;
  always #5 ctrl_clk = ~ctrl_clk;

  // Simple CSR file: combinational read, write on the clock edge.
  logic [31:0] csr_mem [4096];
  assign csr_rdata = csr_mem[csr_addr];
  always @(posedge ctrl_clk) if (csr_wen === 1'b1) csr_mem[csr_addr] <= csr_wdata;

  typedef struct {
    logic [31:0] rdata;
    logic        ill;
  } resp_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
  } wr_t;

  resp_t resp_q[$];
  wr_t   wr_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or hands over a response.
  always @(negedge ctrl_clk) begin
    if (req_valid === 1'b1 && req_ready === 1'b1) acc_cnt++;
    if (csr_wen === 1'b1) begin
      if (wr_q.size() == 0) begin
        check("wen_unexpected", {31'd0, csr_wen}, 32'd0);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        check("wr_addr", {20'd0, csr_addr}, {20'd0, w.addr});
        check("wr_data", csr_wdata, w.wdata);
      end
    end
    if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
      rsp_cnt++;
      if (resp_q.size() == 0) begin
        check("resp_unexpected", {31'd0, resp_valid}, 32'd0);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        check("resp_rdata", resp_rdata, r.rdata);
        check("resp_illegal", {31'd0, resp_illegal}, {31'd0, r.ill});
      end
    end
  end

  // Issue one instruction, check its cycle-by-cycle timing, hold the
  // response for 'hold' extra cycles, then accept it.
  task automatic issue(input logic [2:0] f3, input logic [11:0] csr, input logic [4:0] src,
                       input logic [31:0] rs1, input logic [1:0] priv,
                       input logic [31:0] exp_rdata, input logic exp_ill,
                       input logic exp_wen, input logic [31:0] exp_wdata, input int hold);
    resp_t r;
    wr_t   w;
    r.rdata = exp_rdata;
    r.ill   = exp_ill;
    resp_q.push_back(r);
    if (exp_wen) begin
      w.addr  = csr;
      w.wdata = exp_wdata;
      wr_q.push_back(w);
    end
    @(posedge ctrl_clk); #1;
    req_valid   = 1'b1;
    req_funct3  = f3;
    req_csr     = csr;
    req_src     = src;
    req_rs1_val = rs1;
    req_priv    = priv;
    resp_ready  = 1'b0;
    @(negedge ctrl_clk);
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge ctrl_clk); #1;
    req_valid = 1'b0;
    @(negedge ctrl_clk);
    check("read_addr", {20'd0, csr_addr}, {20'd0, csr});
    check("read_busy", {30'd0, req_ready, resp_valid}, 32'd0);
    @(negedge ctrl_clk);
    check("write_addr", {20'd0, csr_addr}, {20'd0, csr});
    @(negedge ctrl_clk);
    check("resp_latency", {31'd0, resp_valid}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge ctrl_clk);
      check("hold_valid_ready", {30'd0, resp_valid, req_ready}, 32'd2);
      check("hold_rdata", resp_rdata, exp_rdata);
    end
    @(posedge ctrl_clk); #1;
    resp_ready = 1'b1;
    @(posedge ctrl_clk); #1;
    resp_ready = 1'b0;
    @(negedge ctrl_clk);
    check("back_to_idle", {30'd0, req_ready, resp_valid}, 32'd2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc0;
    int rsp0;
    resp_t r;
    wr_t   w;
    csr_mem[12'h340] = 32'h1234_5678;
    csr_mem[12'h300] = 32'h0000_0080;
    csr_mem[12'h305] = 32'h0000_0100;
    csr_mem[12'hF14] = 32'h0000_0007;
    csr_mem[12'h100] = 32'h0000_0022;
    csr_mem[12'h000] = 32'h0000_0000;
    ctrl_reset  = 1'b1;
    req_valid   = 1'b0;
    req_funct3  = '0;
    req_csr     = '0;
    req_src     = '0;
    req_rs1_val = '0;
    req_priv    = '0;
    resp_ready  = 1'b0;
    repeat (3) @(posedge ctrl_clk);
    #1 ctrl_reset = 1'b0;
    @(negedge ctrl_clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_flags", {29'd0, resp_valid, csr_wen, resp_illegal}, 32'd0);
    check("rst_csr_addr", {20'd0, csr_addr}, 32'd0);
    check("rst_csr_wdata", csr_wdata, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);

    // CSRRW mscratch with 5 cycles of response backpressure
    issue(3'b001, 12'h340, 5'd1, 32'hDEAD_BEEF, 2'd3, 32'h1234_5678, 1'b0, 1'b1, 32'hDEAD_BEEF, 5);
    // CSRRS / CSRRC on mstatus
    issue(3'b010, 12'h300, 5'd2, 32'h0000_0008, 2'd3, 32'h0000_0080, 1'b0, 1'b1, 32'h0000_0088, 0);
    issue(3'b011, 12'h300, 5'd2, 32'h0000_0008, 2'd3, 32'h0000_0088, 1'b0, 1'b1, 32'h0000_0080, 0);
    // Read-only forms: rs1=x0 / zimm=0 never write
    issue(3'b010, 12'h300, 5'd0, 32'hFFFF_FFFF, 2'd3, 32'h0000_0080, 1'b0, 1'b0, 32'h0, 0);
    issue(3'b110, 12'h340, 5'd0, 32'hFFFF_FFFF, 2'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 0);
    issue(3'b111, 12'h340, 5'd0, 32'hFFFF_FFFF, 2'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 0);
    // Illegal: U-mode to mtvec, write to mhartid, reserved funct3
    issue(3'b010, 12'h305, 5'd0, 32'h0, 2'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1);
    issue(3'b001, 12'hF14, 5'd5, 32'h0000_0001, 2'd3, 32'h0, 1'b1, 1'b0, 32'h0, 0);
    issue(3'b010, 12'hF14, 5'd0, 32'hFFFF_FFFF, 2'd3, 32'h0000_0007, 1'b0, 1'b0, 32'h0, 0);
    issue(3'b100, 12'h340, 5'd3, 32'h0000_0001, 2'd3, 32'h0, 1'b1, 1'b0, 32'h0, 0);
    // Immediate forms: zimm is zero-extended and rs1_val is ignored
    issue(3'b101, 12'h340, 5'h1F, 32'hFFFF_0000, 2'd3, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_001F, 0);
    issue(3'b110, 12'h300, 5'h03, 32'hFFFF_0000, 2'd3, 32'h0000_0080, 1'b0, 1'b1, 32'h0000_0083, 0);
    // S-mode may read sstatus but not an M-level CSR
    issue(3'b010, 12'h100, 5'd0, 32'h0, 2'd1, 32'h0000_0022, 1'b0, 1'b0, 32'h0, 0);
    issue(3'b010, 12'h340, 5'd0, 32'h0, 2'd1, 32'h0, 1'b1, 1'b0, 32'h0, 0);

    // req_valid held for 12 cycles with resp_ready=1: three full transactions
    r.rdata = 32'h0000_001F;
    r.ill   = 1'b0;
    repeat (3) resp_q.push_back(r);
    acc0 = acc_cnt;
    rsp0 = rsp_cnt;
    @(posedge ctrl_clk); #1;
    req_valid   = 1'b1;
    req_funct3  = 3'b010;
    req_csr     = 12'h340;
    req_src     = 5'd0;
    req_rs1_val = 32'h0;
    req_priv    = 2'd3;
    resp_ready  = 1'b1;
    repeat (12) @(posedge ctrl_clk);
    #1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    @(negedge ctrl_clk);
    check("held_accepts", acc_cnt - acc0, 32'd3);
    check("held_responses", rsp_cnt - rsp0, 32'd3);
    check("held_idle", {31'd0, req_ready}, 32'd1);

    // Reset while in WRITE: the in-progress strobe happens, nothing after
    w.addr  = 12'h340;
    w.wdata = 32'hAAAA_5555;
    wr_q.push_back(w);
    @(posedge ctrl_clk); #1;
    req_valid   = 1'b1;
    req_funct3  = 3'b001;
    req_csr     = 12'h340;
    req_src     = 5'd4;
    req_rs1_val = 32'hAAAA_5555;
    req_priv    = 2'd3;
    @(posedge ctrl_clk); #1;
    req_valid = 1'b0;
    @(posedge ctrl_clk); #1;
    ctrl_reset = 1'b1;
    @(posedge ctrl_clk); #1;
    ctrl_reset = 1'b0;
    resp_ready = 1'b1;
    @(negedge ctrl_clk);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge ctrl_clk);
      check("post_rst_quiet", {30'd0, csr_wen, resp_valid}, 32'd0);
    end
    resp_ready = 1'b0;

    check("resp_queue_empty", resp_q.size(), 32'd0);
    check("wr_queue_empty", wr_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_exec_unit.md
Name: csr_exec_unit

Overview:
- Executes Zicsr instructions (CSRRW/RS/RC and immediate forms) for the core. Sits directly upstream of the machine-mode CSR file: it accepts a decoded CSR instruction from the execute stage and issues one read and at most one write to the CSR file. It returns the old CSR value for rd, plus an illegal-instruction flag for the trap logic.
- Multi-cycle, one instruction in flight, valid/ready on both sides.

Parameters:
- XLEN, 32, data width of CSRs, rs1 value and result.

Ports:
- ctrl_clk  in  1  clock.
- ctrl_reset  in  1  synchronous active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_funct3  in  3  instruction funct3.
- req_csr  in  12  CSR address field.
- req_src  in  5  rs1 index (register forms) or zimm (immediate forms).
- req_rs1_val  in  XLEN  rs1 register value (ignored for immediate forms).
- req_priv  in  2  current privilege level (0=U, 1=S, 3=M).
- csr_addr  out  12  address to CSR file.
- csr_wdata  out  XLEN  write data to CSR file.
- csr_wen  out  1  CSR write strobe.
- csr_rdata  in  XLEN  combinational read data from CSR file.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_rdata  out  XLEN  old CSR value (rd writeback).
- resp_illegal  out  1  instruction must raise illegal-instruction exception.

Behaviour:
- Reset: FSM state IDLE. req_ready=1, resp_valid=0, csr_wen=0, csr_addr=0, csr_wdata=0, resp_rdata=0, resp_illegal=0. Reset asserted in any state aborts the operation: no csr_wen is issued afterwards and no response is produced.
- FSM: IDLE -> READ -> WRITE -> RESP -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid, register funct3, csr, src, rs1_val and priv, then go to READ.
- READ (T+1, where T is the accept edge):
  - csr_addr = latched csr.
  - Capture csr_rdata into old_q.
  - Compute new value and illegal; go to WRITE.
- Operand: op = funct3[2] ? zero-extended src : rs1_val.
- New value:
  - funct3[1:0]=01: op.
  - 10: old | op.
  - 11: old & ~op.
- do_write:
  - 1 for funct3[1:0]=01.
  - For 10/11: 1 only if src != 0. The rs1=x0 / zimm=0 case never writes.
- illegal = any of:
  - funct3 in {000, 100}.
  - req_priv < csr[9:8].
  - do_write && csr[11:10]==2'b11 (read-only CSR).
- WRITE (T+2):
  - csr_addr held.
  - csr_wen=1 for exactly this cycle iff do_write && !illegal.
  - csr_wdata = new value; it is 0 whenever wen=0.
  - Go to RESP.
- RESP (T+3 onward):
  - resp_valid=1, resp_rdata=old_q (0 if illegal), resp_illegal=illegal.
  - Outputs are stable until resp_valid && resp_ready. Then go to IDLE, and resp_valid drops the next cycle.
  - req_ready=0 in every state except IDLE. Back-to-back minimum is 4 cycles per instruction, because the request cannot be accepted in the same cycle the response is taken.
- csr_wen is never asserted outside WRITE. It is asserted at most once per accepted request.
- Illegal instructions cause no CSR state change.

Test Plan:
- Reset then CSRRW (funct3=001) to 0x340, rs1_val=0xDEADBEEF, priv=3:
  - csr_addr=0x340 at T+1.
  - csr_wen=1 with wdata=0xDEADBEEF at T+2 only.
  - resp_valid at T+3 with resp_rdata equal to the prior mscratch; illegal=0.
- CSRRS 0x300 with rs1_val=0x8, then CSRRC with rs1_val=0x8, prior mstatus=0x80:
  - First instruction: wdata=0x88, resp_rdata=0x80.
  - Second instruction: wdata=0x80, resp_rdata=0x88.
- CSRRS with src=0 (rs1_val=0xFFFFFFFF) and CSRRSI/CSRRCI with zimm=0:
  - csr_wen stays 0 for every request.
  - resp_rdata equals the current CSR value; illegal=0.
- Illegal cases:
  - priv=0 access to 0x305 -> resp_illegal=1, no wen.
  - CSRRW to 0xF14 -> resp_illegal=1, no wen.
  - CSRRS with src=0 on 0xF14 -> legal.
  - funct3=100 -> illegal.
- Backpressure and handshake:
  - Hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0.
  - Release -> IDLE next cycle.
  - A req_valid held throughout is accepted exactly once per completed response.
- Reset in WRITE state (ctrl_reset high at T+2 edge) -> no csr_wen after reset, resp_valid never asserted, req_ready=1 the cycle after reset.
